// File: rtl/decode_scoreboard.sv
// Issue-control scoreboard between decode and the ALU/MUL pipes: per-register latency countdown, RAW/WAW stall, MUL in-flight count.
// Optional stall/issue statistics counters are built when SCOREBOARD_STATS_EN is defined.
module decode_scoreboard #(
  parameter int REGISTER_WIDTH = 5,
  parameter int ALU_LATENCY    = 1,
  parameter int LOAD_LATENCY   = 2,
  parameter int MUL_LATENCY    = 5,
  parameter int CNT_WIDTH      = $clog2(MUL_LATENCY + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         instr_valid_i,
  input  logic                         instr_is_wb_i,
  input  logic [1:0]                   instr_class_i,
  input  logic [REGISTER_WIDTH-1:0]    rd_i,
  input  logic [REGISTER_WIDTH-1:0]    rs1_i,
  input  logic [REGISTER_WIDTH-1:0]    rs2_i,
  input  logic                         rs1_needed_i,
  input  logic                         rs2_needed_i,
  input  logic                         wb_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0]    wb_wr_reg_i,
  output logic                         stall_o,
  output logic                         alu_valid_o,
  output logic                         ex_valid_o,
  output logic [2**REGISTER_WIDTH-1:0] pending_mask_o,
  output logic [CNT_WIDTH-1:0]         mul_inflight_o
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]                  stall_cycles_o,
  output logic [31:0]                  issued_count_o
`endif
);

  localparam int NUM_REGS = 2**REGISTER_WIDTH;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LOAD = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_RSVD = 2'd3
  } instr_class_e;

  logic [NUM_REGS-1:0]  pending_q;
  logic [NUM_REGS-1:0]  is_mul_q;
  logic [CNT_WIDTH-1:0] remain_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] mul_inflight_q;

  instr_class_e         cls;
  logic [CNT_WIDTH-1:0] issue_lat;
  logic                 raw1;
  logic                 raw2;
  logic                 waw;
  logic                 fire;
  logic                 alloc;
  logic                 mul_inc;
  logic                 mul_dec;

  assign cls = instr_class_e'(instr_class_i);

  // Hazard detection: a source stalls only while its producer's result is not yet on the bypass net;
  // a destination stalls if this instruction would reach the bypass net no later than the older writer.
  always_comb begin
    issue_lat = CNT_WIDTH'(ALU_LATENCY);
    case (cls)
      CLS_LOAD: issue_lat = CNT_WIDTH'(LOAD_LATENCY);
      CLS_MUL:  issue_lat = CNT_WIDTH'(MUL_LATENCY);
      default:  issue_lat = CNT_WIDTH'(ALU_LATENCY);
    endcase

    raw1 = rs1_needed_i && (rs1_i != '0) && pending_q[rs1_i] && (remain_q[rs1_i] != '0);
    raw2 = rs2_needed_i && (rs2_i != '0) && pending_q[rs2_i] && (remain_q[rs2_i] != '0);
    waw  = instr_is_wb_i && (rd_i != '0) && pending_q[rd_i] && (remain_q[rd_i] >= issue_lat);

    stall_o     = instr_valid_i && !flush_i && (raw1 || raw2 || waw);
    fire        = instr_valid_i && !flush_i && !stall_o;
    alu_valid_o = fire && (cls != CLS_MUL);
    ex_valid_o  = fire && (cls == CLS_MUL);
    alloc       = fire && instr_is_wb_i && (rd_i != '0);

    mul_inc = ex_valid_o;
    mul_dec = wb_wr_en_i && pending_q[wb_wr_reg_i] && is_mul_q[wb_wr_reg_i];
  end

  // Per-register entries; a new allocation overrides a writeback clear of the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      is_mul_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) begin
        remain_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (alloc && (rd_i == REGISTER_WIDTH'(r))) begin
          pending_q[r] <= 1'b1;
          remain_q[r]  <= issue_lat - CNT_WIDTH'(1);
          is_mul_q[r]  <= (cls == CLS_MUL);
        end else if (wb_wr_en_i && (wb_wr_reg_i == REGISTER_WIDTH'(r))) begin
          pending_q[r] <= 1'b0;
          remain_q[r]  <= '0;
          is_mul_q[r]  <= 1'b0;
        end else if (pending_q[r] && (remain_q[r] != '0)) begin
          remain_q[r]  <= remain_q[r] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Saturating count of multiplies between issue and register-file writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_inflight_q <= '0;
    end else if (mul_inc && !mul_dec && (mul_inflight_q != {CNT_WIDTH{1'b1}})) begin
      mul_inflight_q <= mul_inflight_q + CNT_WIDTH'(1);
    end else if (mul_dec && !mul_inc && (mul_inflight_q != '0)) begin
      mul_inflight_q <= mul_inflight_q - CNT_WIDTH'(1);
    end
  end

  assign pending_mask_o = pending_q;
  assign mul_inflight_o = mul_inflight_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] issued_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      issued_count_q <= '0;
    end else begin
      if (stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (fire)    issued_count_q <= issued_count_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign issued_count_o = issued_count_q;
`endif

endmodule

// File: tb/tb_decode_scoreboard.sv
// Self-checking bench for decode_scoreboard: directed vector table, reset corner case, randomized run against a timing model.
module tb_decode_scoreboard;

  localparam int RW      = 5;
  localparam int NREGS   = 32;
  localparam int ALU_LAT = 1;
  localparam int LD_LAT  = 2;
  localparam int MUL_LAT = 5;
  localparam int CW      = 3;
  localparam int MUL_MAX = 7;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic          instr_valid_i;
  logic          instr_is_wb_i;
  logic [1:0]    instr_class_i;
  logic [RW-1:0] rd_i;
  logic [RW-1:0] rs1_i;
  logic [RW-1:0] rs2_i;
  logic          rs1_needed_i;
  logic          rs2_needed_i;
  logic          wb_wr_en_i;
  logic [RW-1:0] wb_wr_reg_i;
  logic          stall_o;
  logic          alu_valid_o;
  logic          ex_valid_o;
  logic [NREGS-1:0] pending_mask_o;
  logic [CW-1:0] mul_inflight_o;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]   stall_cycles_o;
  logic [31:0]   issued_count_o;
`endif

  int pass_count;
  int total_count;

  decode_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .instr_valid_i  (instr_valid_i),
    .instr_is_wb_i  (instr_is_wb_i),
    .instr_class_i  (instr_class_i),
    .rd_i           (rd_i),
    .rs1_i          (rs1_i),
    .rs2_i          (rs2_i),
    .rs1_needed_i   (rs1_needed_i),
    .rs2_needed_i   (rs2_needed_i),
    .wb_wr_en_i     (wb_wr_en_i),
    .wb_wr_reg_i    (wb_wr_reg_i),
    .stall_o        (stall_o),
    .alu_valid_o    (alu_valid_o),
    .ex_valid_o     (ex_valid_o),
    .pending_mask_o (pending_mask_o),
    .mul_inflight_o (mul_inflight_o)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles_o (stall_cycles_o),
    .issued_count_o (issued_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          valid;
    logic          flush;
    logic          is_wb;
    logic [1:0]    cls;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic          n1;
    logic          wb_en;
    logic [RW-1:0] wb_reg;
    logic          exp_stall;
    logic          exp_alu;
    logic          exp_ex;
    logic [RW-1:0] chk_reg;
    logic          exp_pend;
    logic [CW-1:0] exp_mul;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(input logic v, input logic f, input logic w, input logic [1:0] c,
                              input logic [RW-1:0] rd, input logic [RW-1:0] rs1, input logic n1,
                              input logic we, input logic [RW-1:0] wr,
                              input logic es, input logic ea, input logic ee,
                              input logic [RW-1:0] cr, input logic ep, input logic [CW-1:0] em);
    vec_t t;
    t.valid = v; t.flush = f; t.is_wb = w; t.cls = c; t.rd = rd; t.rs1 = rs1; t.n1 = n1;
    t.wb_en = we; t.wb_reg = wr; t.exp_stall = es; t.exp_alu = ea; t.exp_ex = ee;
    t.chk_reg = cr; t.exp_pend = ep; t.exp_mul = em;
    return t;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic drive_idle();
    flush_i = 0; instr_valid_i = 0; instr_is_wb_i = 0; instr_class_i = 0;
    rd_i = 0; rs1_i = 0; rs2_i = 0; rs1_needed_i = 0; rs2_needed_i = 0;
    wb_wr_en_i = 0; wb_wr_reg_i = 0;
  endtask

  task automatic apply_stimulus(input vec_t t, input int idx);
    @(negedge clk);
    flush_i = t.flush; instr_valid_i = t.valid; instr_is_wb_i = t.is_wb; instr_class_i = t.cls;
    rd_i = t.rd; rs1_i = t.rs1; rs1_needed_i = t.n1; rs2_i = 0; rs2_needed_i = 0;
    wb_wr_en_i = t.wb_en; wb_wr_reg_i = t.wb_reg;
    #2;
    check_output($sformatf("vec%0d stall", idx), 64'(stall_o), 64'(t.exp_stall));
    check_output($sformatf("vec%0d alu_valid", idx), 64'(alu_valid_o), 64'(t.exp_alu));
    check_output($sformatf("vec%0d ex_valid", idx), 64'(ex_valid_o), 64'(t.exp_ex));
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d pending[%0d]", idx, t.chk_reg), 64'(pending_mask_o[t.chk_reg]), 64'(t.exp_pend));
    check_output($sformatf("vec%0d mul_inflight", idx), 64'(mul_inflight_o), 64'(t.exp_mul));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Timing model: each in-flight register remembers the cycle its value reaches the bypass net.
  bit pend  [NREGS];
  bit ismul [NREGS];
  int ready [NREGS];
  int mulcnt;
  int cyc;

  function automatic int lat_of(input logic [1:0] c);
    if (c == 2'd1) return LD_LAT;
    if (c == 2'd2) return MUL_LAT;
    return ALU_LAT;
  endfunction

  task automatic random_phase(input int n);
    logic [NREGS-1:0] exp_mask;
    bit raw1, raw2, waw, st, fire, dec, inc;
    int lat;
    for (int r = 0; r < NREGS; r++) begin pend[r] = 0; ismul[r] = 0; ready[r] = 0; end
    mulcnt = 0;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      instr_valid_i = ($urandom_range(0, 9) < 8);
      flush_i       = ($urandom_range(0, 9) == 0);
      instr_is_wb_i = ($urandom_range(0, 9) < 8);
      instr_class_i = 2'($urandom_range(0, 3));
      rd_i          = RW'($urandom_range(0, 7));
      rs1_i         = RW'($urandom_range(0, 7));
      rs2_i         = RW'($urandom_range(0, 7));
      rs1_needed_i  = $urandom_range(0, 1);
      rs2_needed_i  = $urandom_range(0, 1);
      wb_wr_en_i    = ($urandom_range(0, 9) < 4);
      wb_wr_reg_i   = RW'($urandom_range(0, 7));
      lat  = lat_of(instr_class_i);
      raw1 = rs1_needed_i && rs1_i != 0 && pend[rs1_i] && cyc < ready[rs1_i];
      raw2 = rs2_needed_i && rs2_i != 0 && pend[rs2_i] && cyc < ready[rs2_i];
      waw  = instr_is_wb_i && rd_i != 0 && pend[rd_i] && (cyc + lat <= ready[rd_i]);
      st   = instr_valid_i && !flush_i && (raw1 || raw2 || waw);
      fire = instr_valid_i && !flush_i && !st;
      #2;
      check_output("rand stall", 64'(stall_o), 64'(st));
      check_output("rand alu_valid", 64'(alu_valid_o), 64'(fire && instr_class_i != 2'd2));
      check_output("rand ex_valid", 64'(ex_valid_o), 64'(fire && instr_class_i == 2'd2));
      inc = fire && instr_class_i == 2'd2;
      dec = wb_wr_en_i && pend[wb_wr_reg_i] && ismul[wb_wr_reg_i];
      if (wb_wr_en_i) begin pend[wb_wr_reg_i] = 0; ismul[wb_wr_reg_i] = 0; end
      if (fire && instr_is_wb_i && rd_i != 0) begin
        pend[rd_i]  = 1;
        ismul[rd_i] = (instr_class_i == 2'd2);
        ready[rd_i] = cyc + lat;
      end
      if (inc && !dec && mulcnt < MUL_MAX) mulcnt++;
      if (dec && !inc && mulcnt > 0) mulcnt--;
      @(posedge clk);
      cyc++;
      #1;
      for (int r = 0; r < NREGS; r++) exp_mask[r] = pend[r];
      check_output("rand pending_mask", 64'(pending_mask_o), 64'(exp_mask));
      check_output("rand mul_inflight", 64'(mul_inflight_o), 64'(mulcnt));
    end
  endtask

  initial begin
    pass_count  = 0;
    total_count = 0;
    rst = 1'b1;
    drive_idle();
    #1;
    check_output("reset pending_mask", 64'(pending_mask_o), 64'd0);
    check_output("reset mul_inflight", 64'(mul_inflight_o), 64'd0);
    check_output("reset stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    //            v  f  w  cls rd  rs1 n1 we wr  st al ex chk pd mul
    vecs[0]  = mk(1, 0, 1, 0,  5,  0,  0, 0, 0,  0, 1, 0, 5,  1, 0);
    vecs[1]  = mk(1, 0, 1, 0,  10, 5,  1, 1, 5,  0, 1, 0, 5,  0, 0);
    vecs[2]  = mk(0, 0, 0, 0,  0,  0,  0, 1, 10, 0, 0, 0, 10, 0, 0);
    vecs[3]  = mk(1, 0, 1, 2,  6,  0,  0, 0, 0,  0, 0, 1, 6,  1, 1);
    vecs[4]  = mk(1, 0, 1, 0,  11, 6,  1, 0, 0,  1, 0, 0, 6,  1, 1);
    vecs[5]  = mk(1, 0, 1, 0,  11, 6,  1, 0, 0,  1, 0, 0, 6,  1, 1);
    vecs[6]  = mk(1, 0, 1, 0,  11, 6,  1, 0, 0,  1, 0, 0, 6,  1, 1);
    vecs[7]  = mk(1, 0, 1, 0,  11, 6,  1, 0, 0,  1, 0, 0, 6,  1, 1);
    vecs[8]  = mk(1, 0, 1, 0,  11, 6,  1, 0, 0,  0, 1, 0, 11, 1, 1);
    vecs[9]  = mk(0, 0, 0, 0,  0,  0,  0, 1, 6,  0, 0, 0, 6,  0, 0);
    vecs[10] = mk(0, 0, 0, 0,  0,  0,  0, 1, 11, 0, 0, 0, 11, 0, 0);
    vecs[11] = mk(1, 0, 1, 2,  7,  0,  0, 0, 0,  0, 0, 1, 7,  1, 1);
    vecs[12] = mk(1, 0, 1, 0,  7,  0,  0, 0, 0,  1, 0, 0, 7,  1, 1);
    vecs[13] = mk(1, 0, 1, 0,  7,  0,  0, 0, 0,  1, 0, 0, 7,  1, 1);
    vecs[14] = mk(1, 0, 1, 0,  7,  0,  0, 0, 0,  1, 0, 0, 7,  1, 1);
    vecs[15] = mk(1, 0, 1, 0,  7,  0,  0, 0, 0,  1, 0, 0, 7,  1, 1);
    vecs[16] = mk(1, 0, 1, 0,  7,  0,  0, 1, 7,  0, 1, 0, 7,  1, 0);
    vecs[17] = mk(0, 0, 0, 0,  0,  0,  0, 1, 7,  0, 0, 0, 7,  0, 0);
    vecs[18] = mk(1, 0, 1, 0,  9,  0,  0, 0, 0,  0, 1, 0, 9,  1, 0);
    vecs[19] = mk(1, 0, 1, 0,  9,  0,  0, 1, 9,  0, 1, 0, 9,  1, 0);
    vecs[20] = mk(0, 0, 0, 0,  0,  0,  0, 1, 9,  0, 0, 0, 9,  0, 0);
    vecs[21] = mk(1, 0, 1, 2,  12, 0,  0, 0, 0,  0, 0, 1, 12, 1, 1);
    vecs[22] = mk(1, 1, 1, 2,  3,  12, 1, 0, 0,  0, 0, 0, 3,  0, 1);
    vecs[23] = mk(1, 0, 1, 0,  0,  0,  0, 0, 0,  0, 1, 0, 0,  0, 1);
    vecs[24] = mk(0, 0, 0, 0,  0,  0,  0, 1, 12, 0, 0, 0, 12, 0, 0);
    vecs[25] = mk(1, 0, 1, 1,  13, 0,  0, 0, 0,  0, 1, 0, 13, 1, 0);
    vecs[26] = mk(1, 0, 1, 0,  14, 13, 1, 0, 0,  1, 0, 0, 13, 1, 0);
    vecs[27] = mk(1, 0, 1, 0,  14, 13, 1, 0, 0,  0, 1, 0, 14, 1, 0);
    vecs[28] = mk(1, 0, 1, 3,  15, 14, 1, 0, 0,  0, 1, 0, 15, 1, 0);
    vecs[29] = mk(1, 0, 1, 0,  16, 15, 1, 0, 0,  0, 1, 0, 16, 1, 0);

    $display("[TB] directed vector table");
    for (int i = 0; i < 30; i++) apply_stimulus(vecs[i], i);

    $display("[TB] reset with entries in flight");
    do_reset();
    apply_stimulus(mk(1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1), 100);
    apply_stimulus(mk(1, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0, 1, 2, 1, 2), 101);
    apply_stimulus(mk(1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 3, 1, 2), 102);
    check_output("pre-reset pending_mask", 64'(pending_mask_o), 64'h0000_000E);
    @(negedge clk);
    instr_valid_i = 1; flush_i = 0; instr_is_wb_i = 1; instr_class_i = 0;
    rd_i = 4; rs1_i = 1; rs1_needed_i = 1; wb_wr_en_i = 0;
    #1;
    check_output("pre-reset raw stall", 64'(stall_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_output("mid reset pending_mask", 64'(pending_mask_o), 64'd0);
    check_output("mid reset mul_inflight", 64'(mul_inflight_o), 64'd0);
    check_output("mid reset stall", 64'(stall_o), 64'd0);
`ifdef SCOREBOARD_STATS_EN
    check_output("mid reset stall_cycles", 64'(stall_cycles_o), 64'd0);
    check_output("mid reset issued_count", 64'(issued_count_o), 64'd0);
`endif
    drive_idle();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] randomized run against model");
    random_phase(3000);

    drive_idle();
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
